spi_reg_bank: RTL and testbench
===============================

# spi_reg_bank

Oversampled SPI slave register bank, directly upstream of `mux_spi`. It decodes MCU transactions on the primary chip select and holds the control registers, including `reg_spi_mux`, which selects the peripheral `mux_spi` routes to. It also produces the `dout` bit that `mux_spi` forwards to the MCU MISO pin whenever the secondary chip select is inactive. All SPI inputs are sampled in the `clk` domain; no logic is clocked by `spi_clk`.

## Interface
- `ID_VALUE`, default 24'hD0_0001: read-only identification value at address 0x03.
- `clk`  in  1: system clock; must be ≥ 8× the SPI clock frequency.
- `rst`  in  1: asynchronous, active-high reset.
- `spi_clk`  in  1: SPI clock (mode 0), asynchronous to `clk`.
- `spi_cs`  in  1: register-bank chip select, active low, asynchronous.
- `spi_mosi`  in  1: SPI data in, MSB first.
- `dout`  out  1: serial read data, registered; feeds `mux_spi.dout`.
- `status`  in  24: live status word, readable at address 0x02.
- `reg_led`  out  24: LED/general control register (address 0x00).
- `reg_spi_mux`  out  8: peripheral-select vector for `mux_spi` (address 0x01).
- `write_strobe`  out  1: one-`clk` pulse on each committed write.

## Operation
- Synchronisers: `spi_clk`, `spi_cs` and `spi_mosi` each pass through a 2-FF synchroniser.
- Edge detection: a third flop on `spi_clk` and `spi_cs` provides rise and fall detection.
- Frame: 32 bits, MSB first.
  - bit 31: R/W̄ (1 = read).
  - bits 30:24: address.
  - bits 23:0: data.
- State machine:
  - IDLE: entered on reset or synchronised cs high. On cs fall → SHIFT, with the bit counter cleared to 0.
  - SHIFT: each synchronised `spi_clk` rise shifts `spi_mosi` into a 32-bit receive register and increments a 6-bit counter. The counter saturates at 33, so an overlong frame is marked invalid.
    - After the 8th rise, if R/W̄ = 1, the transmit register loads the addressed value.
    - On cs rise → COMMIT.
  - COMMIT (1 cycle): if counter == 32 and R/W̄ = 0 and the address is writable, update the register and pulse `write_strobe`. Then → IDLE.
- Register map:
  - 0x00 `reg_led`: RW, 24 bits.
  - 0x01 `reg_spi_mux`: RW. Writes take data[7:0]; reads return {16'h0, reg_spi_mux}.
  - 0x02 `status`: RO. Captured into the transmit register at load time.
  - 0x03 `ID_VALUE`: RO.
  - Any other address: reads return 0; writes are ignored with no strobe.
- Read output: on each synchronised `spi_clk` fall after the load, `dout` presents the next transmit bit, MSB (data bit 23) first.
  - During the command byte, `dout` = 0.
  - In IDLE, `dout` = 0.
- Aborted frames: a cs rise with counter ≠ 32 (short, long, or mid-frame abort) commits nothing. Registers and `write_strobe` are unaffected.
- No mid-frame changes: `reg_spi_mux` changes only in COMMIT, i.e. while cs is high. `mux_spi` therefore never sees a select change during a transfer.

## Timing
- Reset values:
  - `reg_led` = 0.
  - `reg_spi_mux` = 8'h00 (no peripheral selected).
  - `dout` = 0.
  - `write_strobe` = 0.
  - State = IDLE; counter = 0.
- Input latency: pin to synchronised edge detect is 3 `clk` edges.
- Write latency: a register update and `write_strobe` occur on the `clk` edge 4 cycles after `spi_cs` rises at the pin. `write_strobe` is high for exactly 1 cycle.
- `dout` timing: `dout` updates at most 4 `clk` after the `spi_clk` falling edge at the pin. With `clk` ≥ 8× `spi_clk`, it settles before the next SPI rising edge.
- Read data is captured at the 8th `spi_clk` rise plus 3 `clk`. A write to the same register committed in an earlier frame is visible.
- Simultaneous events: a cs rise and a `spi_clk` rise detected in the same cycle are resolved in favour of the cs rise, so the frame ends and the final clock is not counted.
- Asynchronous reset: `rst` asserted mid-frame returns the block to IDLE immediately and clears all registers. The frame in progress is lost.
- Back-to-back frames: a minimum cs-high time of 2 `clk` cycles is supported between frames.

## Test plan
- Reset check: after reset, verify `reg_spi_mux` = 0, `reg_led` = 0 and `dout` = 0. Read 0x03 and verify the returned data bits = 24'hD00001.
- Write `reg_spi_mux`: write frame 0x01_0000A5.
  - `reg_spi_mux` = 8'hA5 exactly 4 `clk` after the cs rise.
  - `write_strobe` pulses for 1 cycle.
  - Reading 0x01 returns 24'h0000A5.
- Short frame: write 0x00 with only 31 clocks, then cs rise.
  - `reg_led` remains unchanged.
  - No `write_strobe`.
  - A following valid 32-bit write of 0x00_123456 sets `reg_led` = 24'h123456.
- Status readback: with `status` = 24'hC0FFEE, read 0x02 at `clk` = 8× `spi_clk`.
  - MISO bits 23:0 = C0FFEE.
  - `dout` = 0 during the command byte.
- Protected and unmapped addresses: write 0x03 and 0x7F.
  - No strobe; ID and all other registers unchanged.
  - A read of 0x7F returns 0.
- Reset mid-frame: assert `rst` after 20 clocks of a write to 0x01, then release it.
  - `reg_spi_mux` = 0.
  - A subsequent complete frame writes correctly.

Source files
------------

// File: rtl/spi_reg_bank.sv
// Oversampled SPI slave register bank: decodes 32-bit MCU frames in the clk domain
// and holds the LED and SPI-mux control registers, with serial readback on dout.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | chip select inactive; waiting for a synchronised cs fall
// ST_SHIFT  | frame in progress; shifting MOSI in, read data out on dout
// ST_COMMIT | one cycle after cs rise; commits a valid 32-bit write
module spi_reg_bank #(
   parameter logic [23:0] ID_VALUE = 24'hD0_0001
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        spi_clk,
   input  logic        spi_cs,
   input  logic        spi_mosi,
   output logic        dout,
   input  logic [23:0] status,
   output logic [23:0] reg_led,
   output logic [7:0]  reg_spi_mux,
   output logic        write_strobe
);

   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_COMMIT} state_t;

   state_t      state_q, state_d;
   logic [2:0]  sclk_sync;
   logic [2:0]  cs_sync;
   logic [1:0]  mosi_sync;
   logic        sclk_rise, sclk_fall, cs_rise, cs_fall;
   logic        shift_en, drive_en, load_en, commit_ok;
   logic [5:0]  bit_cnt;
   logic [31:0] rx_q, rx_next;
   logic [23:0] tx_q, rd_data;
   logic        tx_live;
   logic [6:0]  cmd_addr;

   // cs synchroniser resets high so a released reset never looks like a frame start
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_sync <= 3'b000;
         cs_sync   <= 3'b111;
         mosi_sync <= 2'b00;
      end else begin
         sclk_sync <= {sclk_sync[1:0], spi_clk};
         cs_sync   <= {cs_sync[1:0], spi_cs};
         mosi_sync <= {mosi_sync[0], spi_mosi};
      end
   end

   assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
   assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
   assign cs_rise   = cs_sync[1] & ~cs_sync[2];
   assign cs_fall   = ~cs_sync[1] & cs_sync[2];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (cs_fall) state_d = ST_SHIFT;
         ST_SHIFT:  if (cs_rise) state_d = ST_COMMIT;
         ST_COMMIT: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // a cs rise wins over a coincident clock edge, so the last edge is dropped
   assign shift_en  = (state_q == ST_SHIFT) && sclk_rise && !cs_rise;
   assign drive_en  = (state_q == ST_SHIFT) && sclk_fall && !cs_rise;
   assign rx_next   = {rx_q[30:0], mosi_sync[1]};
   assign cmd_addr  = rx_next[6:0];
   assign load_en   = shift_en && (bit_cnt == 6'd7) && rx_next[7];
   assign commit_ok = (state_q == ST_COMMIT) && (bit_cnt == 6'd32) && !rx_q[31]
                      && ((rx_q[30:24] == 7'd0) || (rx_q[30:24] == 7'd1));

   always_comb begin
      rd_data = 24'h0;
      case (cmd_addr)
         7'd0:    rd_data = reg_led;
         7'd1:    rd_data = {16'h0, reg_spi_mux};
         7'd2:    rd_data = status;
         7'd3:    rd_data = ID_VALUE;
         default: rd_data = 24'h0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt <= 6'd0;
         rx_q    <= 32'h0;
      end else if ((state_q == ST_IDLE) && cs_fall) begin
         bit_cnt <= 6'd0;
      end else if (shift_en) begin
         rx_q <= rx_next;
         if (bit_cnt != 6'd33) bit_cnt <= bit_cnt + 6'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_q    <= 24'h0;
         tx_live <= 1'b0;
         dout    <= 1'b0;
      end else if (state_q != ST_SHIFT) begin
         tx_live <= 1'b0;
         dout    <= 1'b0;
      end else if (load_en) begin
         tx_q    <= rd_data;
         tx_live <= 1'b1;
      end else if (drive_en) begin
         dout <= tx_live & tx_q[23];
         if (tx_live) tx_q <= {tx_q[22:0], 1'b0};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         reg_led      <= 24'h0;
         reg_spi_mux  <= 8'h00;
         write_strobe <= 1'b0;
      end else begin
         write_strobe <= commit_ok;
         if (commit_ok) begin
            if (rx_q[24]) reg_spi_mux <= rx_q[7:0];
            else          reg_led     <= rx_q[23:0];
         end
      end
   end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Bench for spi_reg_bank: directed frames plus randomized frames checked against a
// register-map model; clk period 10 ns, SPI bit period 80 ns (8x oversampling).
module tb_spi_reg_bank;

   logic        clk = 1'b0;
   logic        rst, spi_clk, spi_cs, spi_mosi, dout, write_strobe;
   logic [23:0] status, reg_led;
   logic [7:0]  reg_spi_mux;

   localparam logic [23:0] ID = 24'hD00001;

   int          n_checks = 0;
   int          n_errors = 0;
   int          strobe_cnt = 0;
   int          mid_frame_chg = 0;
   logic [7:0]  mux_prev = 8'h00;
   logic [23:0] m_led;
   logic [7:0]  m_mux;

   always #5 clk = ~clk;

   spi_reg_bank dut (
      .clk          (clk),
      .rst          (rst),
      .spi_clk      (spi_clk),
      .spi_cs       (spi_cs),
      .spi_mosi     (spi_mosi),
      .dout         (dout),
      .status       (status),
      .reg_led      (reg_led),
      .reg_spi_mux  (reg_spi_mux),
      .write_strobe (write_strobe)
   );

   always @(negedge clk) if (write_strobe === 1'b1) strobe_cnt++;

   always @(negedge clk) begin
      if (spi_cs === 1'b0 && rst === 1'b0 && reg_spi_mux !== mux_prev) mid_frame_chg++;
      mux_prev = reg_spi_mux;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [23:0] model_read(input logic [6:0] a);
      if (a == 7'd0) return m_led;
      if (a == 7'd1) return {16'h0, m_mux};
      if (a == 7'd2) return status;
      if (a == 7'd3) return ID;
      return 24'h0;
   endfunction

   // MISO is sampled 1 ns before each rising edge, as a mode-0 master would
   task automatic spi_xfer(input logic [31:0] frame, input int nbits, input bit raise_cs,
                           output logic [31:0] miso);
      miso = 32'h0;
      @(negedge clk);
      #3;
      spi_cs = 1'b0;
      #40;
      for (int i = 0; i < nbits; i++) begin
         spi_mosi = (i < 32) ? frame[31 - i] : 1'b0;
         #39;
         if (i < 32) miso[31 - i] = dout;
         #1 spi_clk = 1'b1;
         #40 spi_clk = 1'b0;
      end
      #40;
      if (raise_cs) begin
         spi_cs = 1'b1;
         #100;
      end
   endtask

   task automatic run_frame(input string tag, input bit rw, input logic [6:0] addr,
                            input logic [23:0] data, input int nbits);
      logic [31:0] miso;
      logic [23:0] exp_rd;
      int          s0;
      bit          ok;
      exp_rd = model_read(addr);
      s0 = strobe_cnt;
      spi_xfer({rw, addr, data}, nbits, 1'b1, miso);
      ok = !rw && nbits == 32 && addr <= 7'd1;
      if (ok) begin
         if (addr == 7'd0) m_led = data;
         else              m_mux = data[7:0];
      end
      chk({tag, " strobe"}, strobe_cnt - s0, {31'b0, ok});
      chk({tag, " reg_led"}, {8'h0, reg_led}, {8'h0, m_led});
      chk({tag, " reg_spi_mux"}, {24'h0, reg_spi_mux}, {24'h0, m_mux});
      chk({tag, " dout idle"}, {31'b0, dout}, 32'h0);
      if (rw && nbits >= 32) begin
         chk({tag, " read data"}, {8'h0, miso[23:0]}, {8'h0, exp_rd});
         chk({tag, " cmd byte dout"}, {24'h0, miso[31:24]}, 32'h0);
      end
   endtask

   initial begin
      logic [31:0] miso;
      int          s0, nbits, r;
      bit          rw;
      logic [6:0]  addr;
      logic [23:0] data;

      rst = 1'b1; spi_cs = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0; status = 24'h0;
      m_led = 24'h0; m_mux = 8'h00;
      #23 rst = 1'b0;
      #30;

      chk("reset reg_spi_mux", {24'h0, reg_spi_mux}, 32'h0);
      chk("reset reg_led", {8'h0, reg_led}, 32'h0);
      chk("reset dout", {31'b0, dout}, 32'h0);
      chk("reset strobe", {31'b0, write_strobe}, 32'h0);
      run_frame("read id", 1'b1, 7'h03, 24'h0, 32);

      // write latency: update and strobe exactly on the 4th clk edge after cs rises
      s0 = strobe_cnt;
      spi_xfer(32'h010000A5, 32, 1'b0, miso);
      @(negedge clk);
      #2 spi_cs = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("lat edge3 strobe", {31'b0, write_strobe}, 32'h0);
      chk("lat edge3 mux", {24'h0, reg_spi_mux}, {24'h0, m_mux});
      @(posedge clk);
      #1;
      chk("lat edge4 mux", {24'h0, reg_spi_mux}, 32'hA5);
      chk("lat edge4 strobe", {31'b0, write_strobe}, 32'h1);
      @(posedge clk);
      #1;
      chk("lat edge5 strobe", {31'b0, write_strobe}, 32'h0);
      m_mux = 8'hA5;
      #100;
      chk("lat strobe count", strobe_cnt - s0, 32'h1);
      run_frame("read mux", 1'b1, 7'h01, 24'h0, 32);

      run_frame("led pre", 1'b0, 7'h00, 24'h5A5A5A, 32);
      run_frame("short", 1'b0, 7'h00, 24'hFFFFFF, 31);
      run_frame("long", 1'b0, 7'h00, 24'hFFFFFF, 33);
      run_frame("led write", 1'b0, 7'h00, 24'h123456, 32);

      status = 24'hC0FFEE;
      run_frame("status", 1'b1, 7'h02, 24'h0, 32);

      run_frame("wr id", 1'b0, 7'h03, 24'hABCDEF, 32);
      run_frame("wr 7f", 1'b0, 7'h7F, 24'hABCDEF, 32);
      run_frame("id after", 1'b1, 7'h03, 24'h0, 32);
      run_frame("read 7f", 1'b1, 7'h7F, 24'h0, 32);

      spi_xfer({1'b0, 7'h01, 24'h00005A}, 20, 1'b0, miso);
      rst = 1'b1;
      #17 spi_cs = 1'b1;
      #20 rst = 1'b0;
      m_led = 24'h0; m_mux = 8'h00;
      #1;
      chk("mid rst mux", {24'h0, reg_spi_mux}, 32'h0);
      chk("mid rst led", {8'h0, reg_led}, 32'h0);
      #50;
      run_frame("post rst", 1'b0, 7'h01, 24'h00003C, 32);

      for (int k = 0; k < 60; k++) begin
         addr = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 3));
         rw = 1'($urandom_range(0, 1));
         data = 24'($urandom);
         status = 24'($urandom);
         r = $urandom_range(0, 9);
         nbits = (r == 0) ? 31 : (r == 1) ? 33 : (r == 2) ? $urandom_range(1, 30) : 32;
         run_frame("rand", rw, addr, data, nbits);
      end

      chk("mux stable in frame", mid_frame_chg, 32'h0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
